// File: rtl/comparador_serial_i_d_if.sv
// comparador_serial_i_d_if: start/operand/verdict bundle for the bit-serial comparator
interface comparador_serial_i_d_if #(parameter int N = 8);
    logic         start;
    logic [N-1:0] a_p;
    logic [N-1:0] b_p;
    logic         busy;
    logic         done;
    logic         p_gt;
    logic         p_eq;
    logic         p_lt;
    modport master (output start, a_p, b_p, input busy, done, p_gt, p_eq, p_lt);
    modport slave  (input start, a_p, b_p, output busy, done, p_gt, p_eq, p_lt);
endinterface

// File: rtl/comparador_serial_i_d.sv
// comparador_serial_i_d: MSB-first bit-serial magnitude comparator; COMPARADOR_EARLY_EXIT_EN finishes as soon as a bit decides
module comparador_serial_i_d #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    comparador_serial_i_d_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMP  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int IW = $clog2(N);

    logic [1:0]    r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [IW-1:0] r_idx;
    logic          r_x;
    logic          r_y;
    logic          r_gt;
    logic          r_eq;
    logic          r_lt;
    logic          w_decide;
    logic          w_x_nxt;
    logic          w_y_nxt;
    logic          w_last;

    // One comparator cell: the current MSB pair decides only while still undecided (x=0)
    always_comb begin
        w_decide = ~r_x & (r_a[N-1] ^ r_b[N-1]);
        w_x_nxt  = r_x | w_decide;
        w_y_nxt  = w_decide ? r_a[N-1] : r_y;
`ifdef COMPARADOR_EARLY_EXIT_EN
        w_last   = (r_idx == '0) | w_decide;
`else
        w_last   = (r_idx == '0);
`endif
    end

    // Control FSM, operand shift registers, x/y state and registered verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_idx   <= IW'(N - 1);
            r_x     <= 1'b0;
            r_y     <= 1'b0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b0;
            r_lt    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (bus.start) begin
                r_a     <= bus.a_p;
                r_b     <= bus.b_p;
                r_idx   <= IW'(N - 1);
                r_x     <= 1'b0;
                r_y     <= 1'b0;
                r_state <= S_CMP;
            end
        end else if (r_state == S_CMP) begin
            r_a <= r_a << 1;
            r_b <= r_b << 1;
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            if (w_last) begin
                r_state <= S_FIN;
                r_gt    <= w_x_nxt & w_y_nxt;
                r_lt    <= w_x_nxt & ~w_y_nxt;
                r_eq    <= ~w_x_nxt;
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end else begin
            r_state <= S_IDLE;
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_FIN);
    assign bus.p_gt = r_gt;
    assign bus.p_eq = r_eq;
    assign bus.p_lt = r_lt;
endmodule
